project_switch_ctrl: RTL and testbench

- Wishbone-configured controller that owns project selection in the multi-project harness.
- Replaces the bare active-project register with a sequenced, glitch-safe switchover:
  1. isolate the pads,
  2. hold the incoming project in reset,
  3. commit the selection,
  4. release.
- Also provides an optional timed auto-rotation through all projects.
- The harness muxes io_out/io_oeb from active_project and gates them with pads_safe.

---
 rtl/project_switch_ctrl_pkg.sv | 36 +++
 rtl/switch_timer.sv | 29 ++
 rtl/project_switch_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_project_switch_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/project_switch_ctrl_pkg.sv
// Shared definitions for the project switch controller: register map,
// STATUS layout and switch sequencer states.
package project_switch_ctrl_pkg;

   localparam logic [3:0] OFF_SELECT   = 4'h0;
   localparam logic [3:0] OFF_STATUS   = 4'h4;
   localparam logic [3:0] OFF_ROTATE   = 4'h8;
   localparam logic [3:0] OFF_RESERVED = 4'hC;

   localparam int unsigned STAT_PEND_TGT_LSB = 8;
   localparam int unsigned STAT_PEND_VALID   = 16;
   localparam int unsigned STAT_BUSY         = 17;
   localparam int unsigned STAT_ERROR        = 18;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISOLATE = 2'd1,
      ST_RESET   = 2'd2
   } switch_state_t;

   function automatic logic [31:0] pack_status(input logic [7:0] active,
                                               input logic [7:0] pend_tgt,
                                               input logic       pend_valid,
                                               input logic       busy,
                                               input logic       error);
      logic [31:0] s;
      s = '0;
      s[7:0]                       = active;
      s[STAT_PEND_TGT_LSB +: 8]    = pend_tgt;
      s[STAT_PEND_VALID]           = pend_valid;
      s[STAT_BUSY]                 = busy;
      s[STAT_ERROR]                = error;
      return s;
   endfunction

endpackage

// File: rtl/switch_timer.sv
// Loadable down-counter; done is high during the last counted cycle and the
// counter parks at zero instead of wrapping.
module switch_timer
   import project_switch_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic             done
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - WIDTH'(1);
      end
   end

   assign done = (count == WIDTH'(1));

endmodule

// File: rtl/project_switch_ctrl.sv
// Wishbone-configured project selector: isolates pads, holds the incoming
// project in reset, commits the selection and releases, with optional rotation.
module project_switch_ctrl
   import project_switch_ctrl_pkg::*;
#(
   parameter logic [31:0] ADDR_BASE    = 32'h3000_0000,
   parameter int unsigned NUM_PROJECTS = 5,
   parameter int unsigned SAFE_CYCLES  = 16,
   parameter int unsigned RESET_CYCLES = 8
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    wb_valid,
   input  logic                    wb_we,
   input  logic [3:0]              wb_sel,
   input  logic [31:0]             wb_adr,
   input  logic [31:0]             wb_dat_i,
   output logic                    wb_ack,
   output logic [31:0]             wb_dat_o,
   output logic [7:0]              active_project,
   output logic [NUM_PROJECTS-1:0] proj_reset,
   output logic                    pads_safe,
   output logic                    switch_busy
);

   localparam logic [7:0] NUM_P8   = 8'(NUM_PROJECTS);
   localparam logic [7:0] LAST_P8  = 8'(NUM_PROJECTS - 1);
   localparam logic [7:0] SAFE_LD  = 8'(SAFE_CYCLES);
   localparam logic [7:0] RESET_LD = 8'(RESET_CYCLES);
   localparam logic [NUM_PROJECTS-1:0] PROJ_RESET_INIT = {NUM_PROJECTS{1'b1}} << 1;

   switch_state_t           state;
   logic [7:0]              target;
   logic [7:0]              pend_target;
   logic                    pend_valid;
   logic                    error;
   logic [31:0]             rot_period;
   logic [31:0]             rot_cnt;
   logic [NUM_PROJECTS-1:0] tgt_onehot;
   logic [31:0]             rdata;
   logic [3:0]              reg_off;
   logic                    in_window, accept, wr, rd;
   logic                    sel_wr, sel_ok, sel_bad, rot_wr, rot_load, stat_clr;
   logic                    take, timer_load, timer_done, rot_expire;
   logic [7:0]              timer_val, rot_next;
   logic                    unused_adr;

   assign unused_adr = ^wb_adr[1:0];
   assign in_window  = (wb_adr[31:4] == ADDR_BASE[31:4]);
   assign reg_off    = {wb_adr[3:2], 2'b00};
   assign accept     = wb_valid & in_window & ~wb_ack;
   assign wr         = accept & wb_we;
   assign rd         = accept & ~wb_we;

   assign sel_wr   = wr && (reg_off == OFF_SELECT) && wb_sel[0];
   assign sel_ok   = sel_wr && (wb_dat_i[7:0] < NUM_P8);
   assign sel_bad  = sel_wr && !(wb_dat_i[7:0] < NUM_P8);
   assign rot_wr   = wr && (reg_off == OFF_ROTATE);
   assign rot_load = rot_wr && (wb_sel == 4'hF);
   assign stat_clr = wr && (reg_off == OFF_STATUS) && wb_dat_i[STAT_ERROR];

   assign switch_busy = (state != ST_IDLE);
   assign take        = (state == ST_IDLE) && pend_valid;
   assign timer_load  = take || ((state == ST_ISOLATE) && timer_done);
   assign timer_val   = take ? SAFE_LD : RESET_LD;

   // Expiry is only honoured with an empty slot, so a post never overlaps a
   // switch already being taken this cycle.
   assign rot_expire = (state == ST_IDLE) && !pend_valid && (rot_period != '0) &&
                       (rot_cnt == rot_period - 32'd1);
   assign rot_next   = (active_project == LAST_P8) ? 8'd0 : active_project + 8'd1;

   always_comb begin
      tgt_onehot = '0;
      for (int unsigned i = 0; i < NUM_PROJECTS; i++) begin
         tgt_onehot[i] = (target == 8'(i));
      end
   end

   always_comb begin
      rdata = '0;
      case (reg_off)
         OFF_SELECT:   rdata = {24'h0, active_project};
         OFF_STATUS:   rdata = pack_status(active_project, pend_target, pend_valid,
                                           switch_busy, error);
         OFF_ROTATE:   rdata = rot_period;
         OFF_RESERVED: rdata = '0;
         default:      rdata = '0;
      endcase
   end

   switch_timer #(.WIDTH(8)) u_timer (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (timer_load),
      .load_val (timer_val),
      .done     (timer_done)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wb_ack     <= 1'b0;
         wb_dat_o   <= '0;
         error      <= 1'b0;
         rot_period <= '0;
      end else begin
         wb_ack   <= accept;
         wb_dat_o <= rd ? rdata : '0;
         if (sel_bad) begin
            error <= 1'b1;
         end else if (stat_clr) begin
            error <= 1'b0;
         end
         if (rot_load) begin
            rot_period <= wb_dat_i;
         end
      end
   end

   // Host write is applied last so it overrides both the take-clear and a rotate post.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pend_valid  <= 1'b0;
         pend_target <= '0;
      end else begin
         if (take) begin
            pend_valid <= 1'b0;
         end
         if (rot_expire && !sel_ok) begin
            pend_valid  <= 1'b1;
            pend_target <= rot_next;
         end
         if (sel_ok) begin
            pend_valid  <= 1'b1;
            pend_target <= wb_dat_i[7:0];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rot_cnt <= '0;
      end else if (rot_wr || (state != ST_IDLE) || pend_valid || (rot_period == '0)) begin
         rot_cnt <= '0;
      end else if (rot_cnt == rot_period - 32'd1) begin
         rot_cnt <= '0;
      end else begin
         rot_cnt <= rot_cnt + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= ST_IDLE;
         target         <= '0;
         active_project <= '0;
         pads_safe      <= 1'b1;
         proj_reset     <= PROJ_RESET_INIT;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pend_valid) begin
                  state     <= ST_ISOLATE;
                  target    <= pend_target;
                  pads_safe <= 1'b1;
               end else begin
                  pads_safe <= 1'b0;
               end
            end
            ST_ISOLATE: begin
               if (timer_done) begin
                  state          <= ST_RESET;
                  active_project <= target;
                  proj_reset     <= '1;
               end
            end
            ST_RESET: begin
               if (timer_done) begin
                  state      <= ST_IDLE;
                  pads_safe  <= 1'b0;
                  proj_reset <= ~tgt_onehot;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_project_switch_ctrl.sv
// Directed bench for project_switch_ctrl: register-access vector table plus
// hand-written switch, queueing, rotation and async-reset sequences.
module tb_project_switch_ctrl;

   localparam logic [31:0] BASE = 32'h3000_0000;
   localparam int unsigned NP   = 5;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          wb_valid, wb_we;
   logic [3:0]    wb_sel;
   logic [31:0]   wb_adr, wb_dat_i;
   logic          wb_ack;
   logic [31:0]   wb_dat_o;
   logic [7:0]    active_project;
   logic [NP-1:0] proj_reset;
   logic          pads_safe, switch_busy;

   project_switch_ctrl #(
      .ADDR_BASE    (BASE),
      .NUM_PROJECTS (NP),
      .SAFE_CYCLES  (16),
      .RESET_CYCLES (8)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .wb_valid       (wb_valid),
      .wb_we          (wb_we),
      .wb_sel         (wb_sel),
      .wb_adr         (wb_adr),
      .wb_dat_i       (wb_dat_i),
      .wb_ack         (wb_ack),
      .wb_dat_o       (wb_dat_o),
      .active_project (active_project),
      .proj_reset     (proj_reset),
      .pads_safe      (pads_safe),
      .switch_busy    (switch_busy)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic        we;
      logic [31:0] adr;
      logic [3:0]  sel;
      logic [31:0] dat;
      logic        exp_ack;
      logic [31:0] exp_rdat;
   } vec_t;

   vec_t vecs[20];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                          input logic [31:0] dat, output logic acked, output logic [31:0] rdat);
      @(negedge clk);
      wb_valid = 1'b1; wb_we = we; wb_adr = adr; wb_sel = sel; wb_dat_i = dat;
      acked = 1'b0;
      rdat  = '0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (wb_ack) begin
            acked = 1'b1;
            rdat  = wb_dat_o;
            break;
         end
      end
      wb_valid = 1'b0; wb_we = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_busy(input logic lvl, input int max_cyc, output int waited);
      waited = -1;
      for (int i = 1; i <= max_cyc; i++) begin
         @(posedge clk); #1;
         if (switch_busy === lvl) begin
            waited = i;
            break;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        acked;
      logic [31:0] rdat;
      logic [3:0]  ack_pat;
      int          n;
      logic        exp_pads, exp_busy;
      logic [7:0]  exp_act;
      logic [NP-1:0] exp_pr;

      reset_n = 1'b0; wb_valid = 1'b0; wb_we = 1'b0; wb_sel = '0; wb_adr = '0; wb_dat_i = '0;

      //            we    address             sel    wdata          ack   rdata
      vecs[0]  = '{1'b0, BASE + 32'h0,      4'hF, 32'h0,         1'b1, 32'h0};
      vecs[1]  = '{1'b0, BASE + 32'h4,      4'hF, 32'h0,         1'b1, 32'h0};
      vecs[2]  = '{1'b0, BASE + 32'h8,      4'hF, 32'h0,         1'b1, 32'h0};
      vecs[3]  = '{1'b1, BASE + 32'h8,      4'hF, 32'h1234_5678, 1'b1, 32'h0};
      vecs[4]  = '{1'b0, BASE + 32'h8,      4'hF, 32'h0,         1'b1, 32'h1234_5678};
      vecs[5]  = '{1'b1, BASE + 32'h8,      4'h7, 32'hDEAD_BEEF, 1'b1, 32'h0};
      vecs[6]  = '{1'b0, BASE + 32'h8,      4'hF, 32'h0,         1'b1, 32'h1234_5678};
      vecs[7]  = '{1'b1, BASE + 32'h8,      4'hF, 32'h0,         1'b1, 32'h0};
      vecs[8]  = '{1'b0, BASE + 32'hC,      4'hF, 32'h0,         1'b1, 32'h0};
      vecs[9]  = '{1'b1, BASE + 32'hC,      4'hF, 32'hFFFF_FFFF, 1'b1, 32'h0};
      vecs[10] = '{1'b0, BASE + 32'hC,      4'hF, 32'h0,         1'b1, 32'h0};
      vecs[11] = '{1'b1, BASE + 32'h0,      4'h1, 32'h7,         1'b1, 32'h0};
      vecs[12] = '{1'b0, BASE + 32'h4,      4'hF, 32'h0,         1'b1, 32'h0004_0000};
      vecs[13] = '{1'b1, BASE + 32'h0,      4'hE, 32'h2,         1'b1, 32'h0};
      vecs[14] = '{1'b0, BASE + 32'h4,      4'hF, 32'h0,         1'b1, 32'h0004_0000};
      vecs[15] = '{1'b1, BASE + 32'h4,      4'hF, 32'h0004_0000, 1'b1, 32'h0};
      vecs[16] = '{1'b0, BASE + 32'h4,      4'hF, 32'h0,         1'b1, 32'h0};
      vecs[17] = '{1'b0, BASE + 32'h10,     4'hF, 32'h0,         1'b0, 32'h0};
      vecs[18] = '{1'b0, 32'h2000_0000,     4'hF, 32'h0,         1'b0, 32'h0};
      vecs[19] = '{1'b1, 32'h4000_0000,     4'h1, 32'h3,         1'b0, 32'h0};

      repeat (3) @(posedge clk);
      #1;
      check("reset active", active_project, 0);
      check("reset pads_safe", pads_safe, 1);
      check("reset busy", switch_busy, 0);
      check("reset proj_reset", proj_reset, 5'b11110);
      check("reset ack", wb_ack, 0);
      check("reset dat_o", wb_dat_o, 0);

      @(negedge clk) reset_n = 1'b1;
      repeat (3) @(negedge clk);
      check("idle pads_safe", pads_safe, 0);

      for (int i = 0; i < 20; i++) begin
         wb_xfer(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat, acked, rdat);
         check($sformatf("vec%0d ack", i), acked, vecs[i].exp_ack);
         if (!vecs[i].we && vecs[i].exp_ack)
            check($sformatf("vec%0d rdata", i), rdat, vecs[i].exp_rdat);
      end
      check("bad select keeps active", active_project, 0);
      check("bad select no busy", switch_busy, 0);

      // Valid held high: ack must alternate, never two in a row.
      @(negedge clk);
      wb_valid = 1'b1; wb_we = 1'b0; wb_adr = BASE; wb_sel = 4'hF;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         ack_pat[3-k] = wb_ack;
      end
      wb_valid = 1'b0;
      check("ack pulse pattern", ack_pat, 4'b1010);
      @(negedge clk);

      // Cycle-exact switch 0 -> 2; cycle 0 is the ack cycle.
      @(negedge clk);
      wb_valid = 1'b1; wb_we = 1'b1; wb_adr = BASE; wb_sel = 4'hF; wb_dat_i = 32'd2;
      @(posedge clk); #1;
      check("sel2 ack", wb_ack, 1);
      check("sel2 cycle0", {pads_safe, switch_busy}, 2'b00);
      wb_valid = 1'b0; wb_we = 1'b0;
      for (int k = 1; k <= 25; k++) begin
         @(posedge clk); #1;
         exp_pads = (k <= 24);
         exp_busy = (k <= 24);
         exp_act  = (k >= 17) ? 8'd2 : 8'd0;
         exp_pr   = (k <= 16) ? 5'b11110 : ((k <= 24) ? 5'b11111 : 5'b11011);
         check($sformatf("sel2 cycle%0d {pads,busy,active,proj_reset}", k),
               {pads_safe, switch_busy, active_project, proj_reset},
               {exp_pads, exp_busy, exp_act, exp_pr});
      end

      // Queued writes while switching to 1: only the last (4) survives.
      @(negedge clk);
      wb_valid = 1'b1; wb_we = 1'b1; wb_adr = BASE; wb_sel = 4'hF; wb_dat_i = 32'd1;
      @(posedge clk); #1;
      check("sel1 ack", wb_ack, 1);
      wb_valid = 1'b0; wb_we = 1'b0;
      wb_xfer(1'b1, BASE, 4'h1, 32'd3, acked, rdat);
      check("queued sel3 ack", acked, 1);
      wb_xfer(1'b1, BASE, 4'h1, 32'd4, acked, rdat);
      check("queued sel4 ack", acked, 1);
      wb_xfer(1'b0, BASE + 32'h4, 4'hF, 32'h0, acked, rdat);
      check("status while busy", rdat, 32'h0003_0402);
      wait_busy(1'b0, 40, n);
      check("switch to 1 finished", n != -1, 1);
      check("switch to 1 active", active_project, 1);
      check("switch to 1 proj_reset", proj_reset, 5'b11101);
      wait_busy(1'b1, 3, n);
      check("pending serviced next cycle", n, 1);
      wait_busy(1'b0, 40, n);
      check("switch to 4 finished", n != -1, 1);
      check("switch to 4 active", active_project, 4);
      check("switch to 4 proj_reset", proj_reset, 5'b01111);
      wait_busy(1'b1, 60, n);
      check("no third switch", n, -1);

      // Rotation 4 -> 0 -> 1 with period 100.
      wb_xfer(1'b1, BASE + 32'h8, 4'hF, 32'd100, acked, rdat);
      check("rotate write ack", acked, 1);
      wait_busy(1'b1, 150, n);
      check("rotate 1st start cycle", n, 101);
      wait_busy(1'b0, 40, n);
      check("rotate wrap to 0", active_project, 0);
      wait_busy(1'b1, 150, n);
      check("rotate 2nd start cycle", n, 101);
      wait_busy(1'b0, 40, n);
      check("rotate 0 to 1", active_project, 1);
      wb_xfer(1'b1, BASE + 32'h8, 4'hF, 32'd0, acked, rdat);

      // Host SELECT=3 lands on the rotate expiry edge (period 10, active 1).
      wb_xfer(1'b1, BASE + 32'h8, 4'hF, 32'd10, acked, rdat);
      repeat (9) @(posedge clk);
      #1;
      wb_valid = 1'b1; wb_we = 1'b1; wb_adr = BASE; wb_sel = 4'h1; wb_dat_i = 32'd3;
      @(posedge clk); #1;
      check("collision ack", wb_ack, 1);
      wb_valid = 1'b0; wb_we = 1'b0;
      wb_xfer(1'b1, BASE + 32'h8, 4'hF, 32'd0, acked, rdat);
      wb_xfer(1'b0, BASE + 32'h4, 4'hF, 32'h0, acked, rdat);
      check("collision status", rdat, 32'h0002_0301);
      wait_busy(1'b0, 40, n);
      check("collision host target", active_project, 3);
      wait_busy(1'b1, 60, n);
      check("collision no rotate switch", n, -1);

      // Async reset in the middle of the RESET phase of a switch 3 -> 2.
      wb_xfer(1'b1, BASE, 4'h1, 32'd2, acked, rdat);
      repeat (18) @(posedge clk);
      #1;
      check("mid RESET phase", {active_project, proj_reset, pads_safe}, {8'd2, 5'b11111, 1'b1});
      #3 reset_n = 1'b0;
      #1;
      check("async active", active_project, 0);
      check("async pads_safe", pads_safe, 1);
      check("async ack", wb_ack, 0);
      check("async busy", switch_busy, 0);
      check("async proj_reset", proj_reset, 5'b11110);
      @(negedge clk) reset_n = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      check("after reset no commit", {active_project, switch_busy, proj_reset}, {8'd0, 1'b0, 5'b11110});
      wb_xfer(1'b0, BASE + 32'h4, 4'hF, 32'h0, acked, rdat);
      check("after reset status", rdat, 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
